// File: rtl/match_controller_if.sv
// Bundles the game-side inputs and HUD/timer-side outputs of the match controller.
// The controller uses the slave view and its environment uses the master view.
interface match_controller_if #(
    parameter int HP_W = 7
);
    logic            tick;
    logic            start_btn;
    logic            pause_btn;
    logic [HP_W-1:0] hp_p1;
    logic [HP_W-1:0] hp_p2;
    logic            timeout;

    logic            timer_rst;
    logic            timer_keep;
    logic            fight_en;
    logic [2:0]      state;
    logic [2:0]      round_num;
    logic [2:0]      p1_wins;
    logic [2:0]      p2_wins;
    logic [1:0]      round_winner;
    logic            match_over;
    logic [1:0]      match_winner;

    modport master (
        output tick, start_btn, pause_btn, hp_p1, hp_p2, timeout,
        input  timer_rst, timer_keep, fight_en, state, round_num,
               p1_wins, p2_wins, round_winner, match_over, match_winner
    );

    modport slave (
        input  tick, start_btn, pause_btn, hp_p1, hp_p2, timeout,
        output timer_rst, timer_keep, fight_en, state, round_num,
               p1_wins, p2_wins, round_winner, match_over, match_winner
    );
endinterface

// File: rtl/match_controller.sv
// Round and match sequencer: runs intro/fight/pause/result phases, decides rounds
// from HP and timer expiry, and tracks wins across a best-of-N match.
module match_controller #(
    parameter int HP_W        = 7,
    parameter int WINS_NEEDED = 2,
    parameter int MAX_ROUNDS  = 5,
    parameter int INTRO_TICKS = 120,
    parameter int END_TICKS   = 180
) (
    input logic               clk,
    input logic               reset,
    match_controller_if.slave mc
);

    localparam int MAX_TICKS = (INTRO_TICKS > END_TICKS) ? INTRO_TICKS : END_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam logic [CNT_W-1:0] INTRO_LAST = CNT_W'(INTRO_TICKS - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(END_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INTRO     = 3'd1,
        FIGHT     = 3'd2,
        PAUSED    = 3'd3,
        ROUND_END = 3'd4,
        MATCH_END = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       roundNum_q, roundNum_d;
    logic [2:0]       p1Wins_q, p1Wins_d;
    logic [2:0]       p2Wins_q, p2Wins_d;
    logic [1:0]       roundWinner_q, roundWinner_d;
    logic             matchOver_q, matchOver_d;
    logic [1:0]       matchWinner_q, matchWinner_d;
    logic             timerRst_q, timerRst_d;
    logic             timerKeep_q, timerKeep_d;
    logic             fightEn_q, fightEn_d;
    logic             startLvl_q, startPrev_q;
    logic             pauseLvl_q, pausePrev_q;

    logic            startEdge, pauseEdge;
    logic [HP_W-1:0] hp1, hp2;
    logic            p1Dead, p2Dead;
    logic [1:0]      outcome;
    logic [1:0]      matchPick;
    logic            matchDone;

    assign startEdge = startLvl_q & ~startPrev_q;
    assign pauseEdge = pauseLvl_q & ~pausePrev_q;
    assign hp1       = mc.hp_p1;
    assign hp2       = mc.hp_p2;
    assign p1Dead    = (hp1 == '0);
    assign p2Dead    = (hp2 == '0);

    // A KO outranks the timer: {p1Dead, p2Dead} is already the winner code (10, 01 or 11).
    always_comb begin
        outcome = 2'b00;
        if (p1Dead || p2Dead) begin
            outcome = {p1Dead, p2Dead};
        end else if (mc.timeout) begin
            if (hp1 > hp2)      outcome = 2'b01;
            else if (hp2 > hp1) outcome = 2'b10;
            else                outcome = 2'b11;
        end
    end

    assign matchPick = (p1Wins_q > p2Wins_q) ? 2'b01 :
                       (p2Wins_q > p1Wins_q) ? 2'b10 : 2'b11;
    assign matchDone = (p1Wins_q == 3'(WINS_NEEDED)) || (p2Wins_q == 3'(WINS_NEEDED)) ||
                       (roundNum_q == 3'(MAX_ROUNDS));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        roundNum_d    = roundNum_q;
        p1Wins_d      = p1Wins_q;
        p2Wins_d      = p2Wins_q;
        roundWinner_d = roundWinner_q;
        matchWinner_d = matchWinner_q;

        case (state_q)
            IDLE: begin
                if (startEdge) begin
                    p1Wins_d   = '0;
                    p2Wins_d   = '0;
                    roundNum_d = 3'd1;
                    state_d    = INTRO;
                end
            end
            INTRO: begin
                if (mc.tick) begin
                    if (cnt_q == INTRO_LAST) state_d = FIGHT;
                    else                     cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            FIGHT: begin
                if (outcome != 2'b00) begin
                    roundWinner_d = outcome;
                    if (outcome == 2'b01)      p1Wins_d = p1Wins_q + 3'd1;
                    else if (outcome == 2'b10) p2Wins_d = p2Wins_q + 3'd1;
                    state_d = ROUND_END;
                end else if (pauseEdge) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pauseEdge) state_d = FIGHT;
            end
            ROUND_END: begin
                if (mc.tick) begin
                    if (cnt_q == END_LAST) begin
                        if (matchDone) begin
                            matchWinner_d = matchPick;
                            state_d       = MATCH_END;
                        end else begin
                            roundNum_d = roundNum_q + 3'd1;
                            state_d    = INTRO;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MATCH_END: begin
                if (startEdge) begin
                    p1Wins_d      = '0;
                    p2Wins_d      = '0;
                    matchWinner_d = 2'b00;
                    roundWinner_d = 2'b00;
                    roundNum_d    = 3'd1;
                    state_d       = INTRO;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry restarts the tick count, and every intro starts with a timer clear.
        if (state_d != state_q) cnt_d = '0;
        if (state_d == INTRO && state_q != INTRO) roundWinner_d = 2'b00;

        timerRst_d  = (state_d == IDLE) || (state_d == INTRO && state_q != INTRO);
        timerKeep_d = (state_d != FIGHT);
        fightEn_d   = (state_d == FIGHT);
        matchOver_d = (state_d == MATCH_END);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            roundNum_q    <= '0;
            p1Wins_q      <= '0;
            p2Wins_q      <= '0;
            roundWinner_q <= 2'b00;
            matchOver_q   <= 1'b0;
            matchWinner_q <= 2'b00;
            timerRst_q    <= 1'b1;
            timerKeep_q   <= 1'b1;
            fightEn_q     <= 1'b0;
            startLvl_q    <= 1'b0;
            startPrev_q   <= 1'b0;
            pauseLvl_q    <= 1'b0;
            pausePrev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            roundNum_q    <= roundNum_d;
            p1Wins_q      <= p1Wins_d;
            p2Wins_q      <= p2Wins_d;
            roundWinner_q <= roundWinner_d;
            matchOver_q   <= matchOver_d;
            matchWinner_q <= matchWinner_d;
            timerRst_q    <= timerRst_d;
            timerKeep_q   <= timerKeep_d;
            fightEn_q     <= fightEn_d;
            startLvl_q    <= mc.start_btn;
            startPrev_q   <= startLvl_q;
            pauseLvl_q    <= mc.pause_btn;
            pausePrev_q   <= pauseLvl_q;
        end
    end

    assign mc.state        = state_q;
    assign mc.round_num    = roundNum_q;
    assign mc.p1_wins      = p1Wins_q;
    assign mc.p2_wins      = p2Wins_q;
    assign mc.round_winner = roundWinner_q;
    assign mc.match_over   = matchOver_q;
    assign mc.match_winner = matchWinner_q;
    assign mc.timer_rst    = timerRst_q;
    assign mc.timer_keep   = timerKeep_q;
    assign mc.fight_en     = fightEn_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomized bench for match_controller: a round/match-level model predicts winners,
// win counts and phase durations, and every observation goes through checkOutput.
module tb_match_controller;

    localparam int HP_W        = 7;
    localparam int WINS_NEEDED = 2;
    localparam int MAX_ROUNDS  = 5;
    localparam int INTRO_TICKS = 3;
    localparam int END_TICKS   = 4;
    localparam int BUDGET      = 400;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   tickPhase   = 0;
    int   mW1, mW2, mRound;

    match_controller_if #(.HP_W(HP_W)) mcIf();

    match_controller #(
        .HP_W(HP_W), .WINS_NEEDED(WINS_NEEDED), .MAX_ROUNDS(MAX_ROUNDS),
        .INTRO_TICKS(INTRO_TICKS), .END_TICKS(END_TICKS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mc(mcIf.slave)
    );

    initial forever #5 clk = ~clk;

    // Frame strobe: one cycle high out of every four.
    initial begin
        mcIf.tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tickPhase = (tickPhase + 1) % 4;
            mcIf.tick = (tickPhase == 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int h1, input int h2, input bit tmo);
        mcIf.hp_p1   = h1[HP_W-1:0];
        mcIf.hp_p2   = h2[HP_W-1:0];
        mcIf.timeout = tmo;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Round verdict straight from the game rules: 0 none, 1 P1, 2 P2, 3 draw.
    function automatic int refOutcome(input int h1, input int h2, input bit tmo);
        if (h1 == 0 && h2 == 0) return 3;
        if (h1 == 0)            return 2;
        if (h2 == 0)            return 1;
        if (!tmo)               return 0;
        if (h1 > h2)            return 1;
        if (h2 > h1)            return 2;
        return 3;
    endfunction

    function automatic int refMatch(input int a, input int b);
        return (a > b) ? 1 : ((b > a) ? 2 : 3);
    endfunction

    // Stay in one state, counting strobes and timer clears seen while there.
    task automatic dwell(input int cur, input bit noise, output int ticks, output int rsts);
        int n;
        n = 0; ticks = 0; rsts = 0;
        while (int'(mcIf.state) == cur && n < BUDGET) begin
            if (mcIf.tick)      ticks++;
            if (mcIf.timer_rst) rsts++;
            if (noise) applyStimulus($urandom_range(0, 127), $urandom_range(0, 127),
                                     $urandom_range(0, 1) == 1);
            @(negedge clk);
            n++;
        end
        checkOutput("dwellExit", (n < BUDGET), 1);
    endtask

    task automatic startMatch(input int fromState);
        mcIf.start_btn = 1'b1;
        @(negedge clk);
        checkOutput("startLatency", mcIf.state, fromState);
        @(negedge clk);
        mRound = 1; mW1 = 0; mW2 = 0;
        checkOutput("startState", mcIf.state, 1);
        checkOutput("startRound", mcIf.round_num, mRound);
        checkOutput("startP1Wins", mcIf.p1_wins, mW1);
        checkOutput("startP2Wins", mcIf.p2_wins, mW2);
        checkOutput("startMatchOver", mcIf.match_over, 0);
        checkOutput("startMatchWinner", mcIf.match_winner, 0);
        checkOutput("startTimerRst", mcIf.timer_rst, 1);
        mcIf.start_btn = 1'b0;
    endtask

    task automatic playRound(input int h1, input int h2, input bit tmo,
                             input bit doPause, input bit simul, output bit done);
        int ticks, rsts, exp;
        checkOutput("introState", mcIf.state, 1);
        checkOutput("introRound", mcIf.round_num, mRound);
        checkOutput("introWinnerClr", mcIf.round_winner, 0);
        applyStimulus(100, 100, 1'b0);
        dwell(1, 1'b0, ticks, rsts);
        checkOutput("introTicks", ticks, INTRO_TICKS);
        checkOutput("introRstPulse", rsts, 1);
        checkOutput("fightState", mcIf.state, 2);
        checkOutput("fightEn", mcIf.fight_en, 1);
        checkOutput("fightKeep", mcIf.timer_keep, 0);
        waitCycles($urandom_range(0, 3));

        if (doPause) begin
            mcIf.pause_btn = 1'b1;
            @(negedge clk);
            checkOutput("pauseLatency", mcIf.state, 2);
            @(negedge clk);
            mcIf.pause_btn = 1'b0;
            checkOutput("pausedState", mcIf.state, 3);
            checkOutput("pausedKeep", mcIf.timer_keep, 1);
            checkOutput("pausedFightEn", mcIf.fight_en, 0);
            applyStimulus(0, 0, 1'b1);
            mcIf.start_btn = 1'b1;
            waitCycles(3);
            checkOutput("pausedHold", mcIf.state, 3);
            checkOutput("pausedWins", mcIf.p1_wins, mW1);
            applyStimulus(100, 100, 1'b0);
            mcIf.start_btn = 1'b0;
            mcIf.pause_btn = 1'b1;
            waitCycles(2);
            mcIf.pause_btn = 1'b0;
            checkOutput("resumeState", mcIf.state, 2);
            checkOutput("resumeFightEn", mcIf.fight_en, 1);
        end

        if (simul) begin
            mcIf.pause_btn = 1'b1;
            @(negedge clk);
            checkOutput("simulPre", mcIf.state, 2);
            mcIf.pause_btn = 1'b0;
        end

        applyStimulus(h1, h2, tmo);
        exp = refOutcome(h1, h2, tmo);
        @(negedge clk);
        if (exp == 1) mW1++;
        if (exp == 2) mW2++;
        checkOutput("decideState", mcIf.state, 4);
        checkOutput("decideFightEn", mcIf.fight_en, 0);
        checkOutput("decideKeep", mcIf.timer_keep, 1);
        checkOutput("roundWinner", mcIf.round_winner, exp);
        checkOutput("p1Wins", mcIf.p1_wins, mW1);
        checkOutput("p2Wins", mcIf.p2_wins, mW2);
        checkOutput("decideMatchOver", mcIf.match_over, 0);

        dwell(4, 1'b1, ticks, rsts);
        checkOutput("endTicks", ticks, END_TICKS);
        applyStimulus(100, 100, 1'b0);
        done = (mW1 == WINS_NEEDED) || (mW2 == WINS_NEEDED) || (mRound == MAX_ROUNDS);
        if (done) begin
            checkOutput("matchEndState", mcIf.state, 5);
            checkOutput("matchOver", mcIf.match_over, 1);
            checkOutput("matchWinner", mcIf.match_winner, refMatch(mW1, mW2));
            checkOutput("matchRound", mcIf.round_num, mRound);
            checkOutput("matchLastWinner", mcIf.round_winner, exp);
            checkOutput("matchKeep", mcIf.timer_keep, 1);
        end else begin
            mRound++;
            checkOutput("nextIntroState", mcIf.state, 1);
            checkOutput("nextRound", mcIf.round_num, mRound);
            checkOutput("nextTimerRst", mcIf.timer_rst, 1);
        end
    endtask

    task automatic randomRound(output bit done);
        int h1, h2;
        bit tmo;
        tmo = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
            0: begin h1 = $urandom_range(1, 127); h2 = 0; end
            1: begin h1 = 0; h2 = $urandom_range(1, 127); end
            2: begin h1 = 0; h2 = 0; end
            default: begin
                h1  = $urandom_range(1, 127);
                h2  = ($urandom_range(0, 3) == 0) ? h1 : $urandom_range(1, 127);
                tmo = 1'b1;
            end
        endcase
        playRound(h1, h2, tmo, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, done);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "State"}, mcIf.state, 0);
        checkOutput({tag, "TimerRst"}, mcIf.timer_rst, 1);
        checkOutput({tag, "TimerKeep"}, mcIf.timer_keep, 1);
        checkOutput({tag, "FightEn"}, mcIf.fight_en, 0);
        checkOutput({tag, "Round"}, mcIf.round_num, 0);
        checkOutput({tag, "P1Wins"}, mcIf.p1_wins, 0);
        checkOutput({tag, "P2Wins"}, mcIf.p2_wins, 0);
        checkOutput({tag, "RoundWinner"}, mcIf.round_winner, 0);
        checkOutput({tag, "MatchOver"}, mcIf.match_over, 0);
        checkOutput({tag, "MatchWinner"}, mcIf.match_winner, 0);
    endtask

    initial begin
        bit done;
        int ticks, rsts;
        reset          = 1'b0;
        mcIf.start_btn = 1'b0;
        mcIf.pause_btn = 1'b0;
        applyStimulus(100, 100, 1'b0);
        mW1 = 0; mW2 = 0; mRound = 0;
        waitCycles(3);
        checkResetValues("rst");
        reset = 1'b1;
        waitCycles(2);
        checkOutput("idleState", mcIf.state, 0);
        checkOutput("idleTimerRst", mcIf.timer_rst, 1);

        $display("[TB] reset, start and KO match");
        startMatch(0);
        playRound(40, 0, 1'b0, 1'b1, 1'b0, done);
        playRound(40, 0, 1'b0, 1'b0, 1'b0, done);
        checkOutput("koMatchDone", done, 1);

        $display("[TB] draws up to the round limit");
        startMatch(5);
        playRound(50, 50, 1'b1, 1'b0, 1'b0, done);
        playRound(0, 0, 1'b0, 1'b0, 1'b1, done);
        playRound(0, 0, 1'b1, 1'b0, 1'b0, done);
        playRound(30, 30, 1'b1, 1'b1, 1'b0, done);
        playRound(0, 0, 1'b0, 1'b0, 1'b0, done);
        checkOutput("limitMatchDone", done, 1);

        $display("[TB] randomized matches");
        for (int m = 0; m < 6; m++) begin
            startMatch(5);
            done = 1'b0;
            for (int r = 0; r < MAX_ROUNDS && !done; r++) randomRound(done);
            checkOutput("randMatchDone", done, 1);
        end

        $display("[TB] reset during round two");
        startMatch(5);
        playRound(40, 0, 1'b0, 1'b0, 1'b0, done);
        checkOutput("midP1Wins", mcIf.p1_wins, 1);
        dwell(1, 1'b0, ticks, rsts);
        checkOutput("midFight", mcIf.state, 2);
        waitCycles(2);
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("midRst");
        reset = 1'b1;
        waitCycles(2);
        startMatch(0);
        playRound(0, 90, 1'b0, 1'b0, 1'b0, done);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
